mux_scan_sequencer: RTL and testbench
=====================================

Name: mux_scan_sequencer

Overview:
Upstream/downstream companion to the lab's 7-to-1 mux. It drives the mux's 3-bit select through codes 0..6 at a programmable rate and samples the mux's 1-bit output at each code. The samples are reassembled into a 7-bit captured word. On the DE1-SoC top level, the select comes from the sequencer, the mux data comes from SW[6:0], and the captured word and status drive the LEDs.

Parameters:
TICKS_PER_SEC, 50000000, number of clock cycles per 1 Hz step; benches override with a small value.
DIV_WIDTH, 28, divider counter width; must hold 4*TICKS_PER_SEC-1.

Ports:
clock  input  1  system clock, all logic on the rising edge
resetn  input  1  synchronous, active-low reset
start  input  1  level; sampled high in IDLE or DONE begins a scan
period_sel  input  2  step rate: 00 every cycle, 01 1x, 10 2x, 11 4x TICKS_PER_SEC cycles per step
mux_bit  input  1  mux output, combinational from mux_select in the same cycle
mux_select  output  3  select code driven to the mux
captured  output  7  captured[i] = mux_bit sampled while mux_select == i
busy  output  1  high in SCAN
done  output  1  high in DONE

Behaviour:
- Reset: on a rising clock edge with resetn=0:
  - state is IDLE.
  - mux_select=0, captured=0, busy=0, done=0, divider=0.
  - Reset applies mid-scan with no completion.
- Step period P is latched from period_sel when a scan starts: P = 1, T, 2T or 4T (T = TICKS_PER_SEC).
  - period_sel changes during SCAN are ignored.
- Divider:
  - Loaded with P-1 on SCAN entry.
  - Tick when the count is 0, with reload to P-1 on the same edge; otherwise decrement.
  - P=1 gives a tick every SCAN cycle.
- IDLE:
  - busy=0, done=0, mux_select=0.
  - start=1 -> SCAN, captured cleared to 0, divider loaded.
- SCAN:
  - busy=1.
  - On tick: captured[mux_select] <= mux_bit.
  - On tick with mux_select==6: go to DONE and set mux_select=0.
  - On tick with any other code: mux_select increments.
  - Codes 7 is never driven.
  - start is ignored.
- DONE:
  - done=1, busy=0; captured is held and mux_select=0.
  - start=1 -> SCAN, same as from IDLE: captured cleared, done drops the next cycle.
- Latency: SCAN lasts exactly 7*P cycles. From the edge that samples start to done=1 is 7*P+1 edges.
- Each select code is held for exactly P consecutive cycles, and mux_bit is sampled in the last cycle of each hold.
- No output is combinational from inputs; all outputs are registered.

Decomposition:
- Shared package:
  - state encoding (IDLE=2'd0, SCAN=2'd1, DONE=2'd2)
  - rate codes (RATE_FULL, RATE_1X, RATE_2X, RATE_4X)
  - LAST_SEL=3'd6
- Sub-module rate_divider:
  - Inputs: clock, resetn, load, period.
  - Output: tick.
  - Holds the down-counter and reload logic. Reused by later rate-divider labs.
- The FSM, select counter and capture register stay in mux_scan_sequencer.

Test Plan:
(Bench: TICKS_PER_SEC=4, a behavioural 7-to-1 mux model closing the loop on mux_select/mux_bit.)
1. Reset: hold resetn=0 three cycles with random start/period_sel -> mux_select=0, captured=0, busy=0, done=0 throughout.
2. Full rate:
   - Stimulus: pattern 7'b1010011, period_sel=00, start pulsed one cycle.
   - Response: mux_select steps 0,1,...,6 one per cycle. busy is high for 7 cycles. done=1 on the 8th edge after start was sampled. captured=7'b1010011.
3. Slow rate:
   - Stimulus: period_sel=01 (P=4), pattern 7'b0110100.
   - Response: each select code is held exactly 4 cycles. done=1 at edge 29. captured=7'b0110100.
4. Ignored inputs:
   - Stimulus: during a P=4 scan, hold start=1 and switch period_sel to 11 at select=2.
   - Response: hold stays 4 cycles per code, no restart, done at edge 29.
5. Reset mid-scan:
   - Stimulus: resetn=0 for one edge while mux_select=3.
   - Response: next cycle IDLE, all outputs 0, done never asserts for that scan.
6. Restart from DONE:
   - Stimulus: after scenario 2, change pattern to 7'b0000001 and assert start.
   - Response: done=0 and captured=0 on the next edge. The new scan ends with captured=7'b0000001.

Source files
------------

// File: rtl/mux_scan_sequencer_pkg.sv
// Shared encodings for the mux scan sequencer: FSM states, step-rate codes
// and the helper that turns a rate code into a step period in clock cycles.
package mux_scan_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RATE_FULL = 2'b00,
        RATE_1X   = 2'b01,
        RATE_2X   = 2'b10,
        RATE_4X   = 2'b11
    } rate_e;

    localparam logic [2:0] LAST_SEL = 3'd6;

    function automatic logic [31:0] rate_period(input rate_e rate, input logic [31:0] ticks);
        logic [31:0] p;
        case (rate)
            RATE_FULL: p = 32'd1;
            RATE_1X:   p = ticks;
            RATE_2X:   p = ticks << 1;
            RATE_4X:   p = ticks << 2;
            default:   p = 32'd1;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/mux_scan_sequencer_rate_divider.sv
// Down-counting rate divider: ticks when the count reaches zero and reloads
// period-1 on the same edge; load restarts the count from period-1.
module rate_divider #(
    parameter int unsigned WIDTH = 28
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] period,
    output logic             tick
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign tick = (cnt_q == '0);

    // Next count: load or terminal count reloads, otherwise count down.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = period - WIDTH'(1);
        end else if (tick) begin
            cnt_d = period - WIDTH'(1);
        end else begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps a 7-to-1 mux select through codes 0..6 at a latched rate and
// reassembles the sampled mux output into a 7-bit captured word.
module mux_scan_sequencer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 50000000,
    parameter int unsigned DIV_WIDTH     = 28
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] period_sel,
    input  logic       mux_bit,
    output logic [2:0] mux_select,
    output logic [6:0] captured,
    output logic       busy,
    output logic       done
);

    state_e                 state_q, state_d;
    logic [2:0]             sel_q, sel_d;
    logic [6:0]             captured_q, captured_d;
    logic [DIV_WIDTH-1:0]   period_q, period_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   load_s;
    logic                   tick_s;

    // period_d is fed straight through so the divider loads the new period on scan entry.
    rate_divider #(.WIDTH(DIV_WIDTH)) u_div (
        .clock  (clock),
        .resetn (resetn),
        .load   (load_s),
        .period (period_d),
        .tick   (tick_s)
    );

    // Next-state, select stepping and capture.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        captured_d = captured_q;
        period_d   = period_q;
        load_s     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                sel_d = 3'd0;
                if (start) begin
                    state_d    = SCAN;
                    captured_d = 7'd0;
                    period_d   = DIV_WIDTH'(rate_period(rate_e'(period_sel), 32'(TICKS_PER_SEC)));
                    load_s     = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            SCAN: begin
                if (tick_s) begin
                    if (sel_q <= LAST_SEL) begin
                        captured_d[sel_q] = mux_bit;
                    end else begin
                        captured_d = captured_q;
                    end
                    if (sel_q >= LAST_SEL) begin
                        state_d = DONE;
                        sel_d   = 3'd0;
                    end else begin
                        sel_d = sel_q + 3'd1;
                    end
                end else begin
                    sel_d = sel_q;
                end
            end
            default: begin
                state_d    = IDLE;
                sel_d      = 3'd0;
                captured_d = 7'd0;
            end
        endcase
        busy_d = (state_d == SCAN);
        done_d = (state_d == DONE);
    end

    // State and output registers; reset aborts any scan in progress.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= IDLE;
            sel_q      <= 3'd0;
            captured_q <= 7'd0;
            period_q   <= DIV_WIDTH'(1);
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            captured_q <= captured_d;
            period_q   <= period_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign mux_select = sel_q;
    assign captured   = captured_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench: stimulus pushes the expected captured word and step period,
// a negedge monitor measures each completed scan and compares.
module tb_mux_scan_sequencer;

    localparam int unsigned TPS = 4;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic [1:0] period_sel;
    logic       mux_bit;
    logic [2:0] mux_select;
    logic [6:0] captured;
    logic       busy;
    logic       done;
    logic [6:0] pattern;

    typedef struct {
        logic [6:0]  cap;
        int unsigned per;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mux_scan_sequencer #(.TICKS_PER_SEC(TPS), .DIV_WIDTH(8)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .period_sel (period_sel),
        .mux_bit    (mux_bit),
        .mux_select (mux_select),
        .captured   (captured),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    // Behavioural 7-to-1 mux closing the loop.
    always_comb begin
        mux_bit = 1'b0;
        if (mux_select < 3'd7) mux_bit = pattern[mux_select];
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: measure hold per code and scan length, compare on done rising.
    int   hold[8];
    int   busy_cycles = 0;
    logic busy_prev = 1'b0;
    logic done_prev = 1'b0;
    always @(negedge clock) begin
        exp_t e;
        if (busy === 1'b1) begin
            if (busy_prev !== 1'b1) begin
                for (int i = 0; i < 8; i++) hold[i] = 0;
                busy_cycles = 0;
            end
            hold[mux_select]++;
            busy_cycles++;
        end
        if (done === 1'b1 && done_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("captured", int'(captured), int'(e.cap));
                check("scan_cycles", busy_cycles, int'(7 * e.per));
                check("busy_before_done", int'(busy_prev), 1);
                for (int i = 0; i < 7; i++) check($sformatf("hold_%0d", i), hold[i], int'(e.per));
            end
        end
        busy_prev = busy;
        done_prev = done;
    end

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (done !== 1'b1) check("done_timeout", 0, 1);
    endtask

    task automatic wait_sel(input logic [2:0] v, input int budget);
        int n = 0;
        while (mux_select !== v && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (mux_select !== v) check("sel_timeout", int'(mux_select), int'(v));
    endtask

    task automatic pulse_start(input logic [1:0] ps, input logic [6:0] pat);
        period_sel = ps;
        pattern    = pat;
        start      = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    initial begin
        logic seen_done;
        resetn     = 1'b0;
        start      = 1'b0;
        period_sel = 2'b00;
        pattern    = 7'd0;

        // Reset with random inputs.
        for (int c = 0; c < 3; c++) begin
            start      = 1'($urandom_range(0, 1));
            period_sel = 2'($urandom_range(0, 3));
            @(negedge clock);
            check("rst_sel", int'(mux_select), 0);
            check("rst_captured", int'(captured), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_done", int'(done), 0);
        end
        start  = 1'b0;
        resetn = 1'b1;
        @(negedge clock);

        // Full rate scan.
        exp_q.push_back('{cap: 7'b1010011, per: 1});
        pulse_start(2'b00, 7'b1010011);
        wait_done(40);

        // Restart straight from DONE with a new pattern.
        exp_q.push_back('{cap: 7'b0000001, per: 1});
        pulse_start(2'b00, 7'b0000001);
        check("restart_done", int'(done), 0);
        check("restart_captured", int'(captured), 0);
        wait_done(40);

        // Slow rate, P = T.
        exp_q.push_back('{cap: 7'b0110100, per: TPS});
        pulse_start(2'b01, 7'b0110100);
        wait_done(100);

        // start held and period_sel changed mid-scan are both ignored.
        exp_q.push_back('{cap: 7'b1100101, per: TPS});
        period_sel = 2'b01;
        pattern    = 7'b1100101;
        start      = 1'b1;
        @(negedge clock);
        wait_sel(3'd2, 100);
        period_sel = 2'b11;
        wait_sel(3'd6, 100);
        start = 1'b0;
        wait_done(100);

        // Reset in the middle of a scan.
        @(negedge clock);
        pulse_start(2'b01, 7'b1111111);
        wait_sel(3'd3, 100);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        check("abort_sel", int'(mux_select), 0);
        check("abort_captured", int'(captured), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        seen_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (done !== 1'b0) seen_done = 1'b1;
        end
        check("abort_no_done", int'(seen_done), 0);
        check("pending_expects", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
